// File: rtl/aes_subbytes_iter.sv
// Iterative AES SubBytes / InvSubBytes engine: LANES bytes substituted per cycle,
// 16/LANES cycles per 128-bit state, valid/ready on both sides.

package aes_gf_pkg;

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] t;
      p = '0;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0 naturally.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      return gf_mul(gf_mul(x240, x12), x2);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] b);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] b);
      return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
   endfunction

endpackage

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes_gf_pkg::*;
   always_comb y = affine_fwd(gf_inv(a));
endmodule

module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   import aes_gf_pkg::*;
   always_comb y = gf_inv(affine_inv(a));
endmodule

module aes_subbytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic         inv_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);
   localparam int BEATS = 16 / LANES;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("aes_subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [127:0]         work_q, work_d;
   logic                 mode_q, mode_d;
   logic                 out_valid_q, out_valid_d;
   logic                 busy_q, busy_d;
   logic                 load;
   logic [CW-1:0]        beat_idx;
   logic [8*LANES-1:0]   beat_in, beat_sub;

   // Beat 0 sits in the most significant bytes, so count slices down from the top.
   always_comb beat_idx = CW'(BEATS - 1) - cnt_q;
   always_comb beat_in  = work_q[8*LANES*beat_idx +: 8*LANES];

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [7:0] fwd_y, inv_y;
      aes_sbox     u_fwd (.a(beat_in[8*(LANES-1-j) +: 8]), .y(fwd_y));
      aes_inv_sbox u_inv (.a(beat_in[8*(LANES-1-j) +: 8]), .y(inv_y));
      assign beat_sub[8*(LANES-1-j) +: 8] = mode_q ? inv_y : fwd_y;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      mode_d  = mode_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               load    = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            work_d[8*LANES*beat_idx +: 8*LANES] = beat_sub;
            if (cnt_q == CW'(BEATS - 1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            // Consumer taking the result frees the engine for a new state in the same edge.
            if (out_ready) begin
               load    = in_valid;
               state_d = in_valid ? BUSY : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         work_d = state_in;
         mode_d = inv_in;
         cnt_d  = '0;
      end
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d == BUSY);
   end

   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign state_out = work_q;

endmodule

// File: tb/tb_aes_subbytes_iter.sv
// Scoreboard bench for aes_subbytes_iter: LANES=4 main instance plus a sweep over 1/2/8/16.
module tb_aes_subbytes_iter;
   localparam int BEATS = 4;
   localparam logic [127:0] V_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] V_SB = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam logic [127:0] V_63 = {16{8'h63}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, rst_sw, in_valid, inv_in, out_ready, in_ready, out_valid, busy;
   logic [127:0] state_in, state_out;
   int           total = 0, bad = 0, cyc = 0, sw_done = 0, or_mode = 1;

   always @(posedge clk) cyc <= cyc + 1;

   aes_subbytes_iter #(.LANES(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in),
      .inv_in(inv_in), .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out),
      .busy(busy));

   // Reference S-boxes built by brute-force inverse search and bitwise affine map.
   logic [7:0] sbox_t [256];
   logic [7:0] isbox_t[256];

   function automatic int gmul(int a, int b);
      int p;
      p = 0;
      for (int i = 0; i < 8; i++) begin
         if ((b & (1 << i)) != 0) p = p ^ a;
         a = a << 1;
         if ((a & 'h100) != 0) a = a ^ 'h11b;
      end
      return p;
   endfunction

   initial begin
      int         inv_v, s;
      logic [7:0] b, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv_v = 0;
         for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv_v = y;
         b = 8'(inv_v);
         s = 0;
         for (int i = 0; i < 8; i++)
            s = s | (int'(b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i]) << i);
         sbox_t[x] = 8'(s);
         isbox_t[s] = 8'(x);
      end
   end

   function automatic logic [127:0] ref_sub(logic [127:0] d, logic inv);
      logic [127:0] r;
      logic [7:0]   bt;
      for (int i = 0; i < 16; i++) begin
         bt = d[127-8*i -: 8];
         r[127-8*i -: 8] = inv ? isbox_t[bt] : sbox_t[bt];
      end
      return r;
   endfunction

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   typedef struct { logic [127:0] exp; int acc; } item_t;
   item_t sb[$];

   // out_ready driver: 0 = low, 1 = high, 2 = random each cycle
   always @(posedge clk) begin
      #2;
      out_ready = (or_mode == 2) ? 1'($urandom_range(0, 1)) : (or_mode == 1);
   end

   // Monitor: latency on rising out_valid, data on each output handshake, hold under backpressure.
   logic         prev_ov = 1'b0, prev_hold = 1'b0;
   logic [127:0] prev_so;
   always @(negedge clk) begin
      if (rst) begin
         prev_ov   = 1'b0;
         prev_hold = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_out_valid: got out_valid=1 want 0 (nothing pending)");
            end else check_int("latency", cyc, sb[0].acc + BEATS);
         end
         if (prev_hold && out_valid) check("hold_state_out", state_out, prev_so);
         if (out_valid && out_ready && sb.size() > 0) begin
            check("result", state_out, sb[0].exp);
            void'(sb.pop_front());
         end
         prev_ov   = out_valid;
         prev_hold = out_valid && !out_ready;
         prev_so   = state_out;
      end
   end

   task automatic slot();
      @(posedge clk); #1;
   endtask

   task automatic send(logic [127:0] d, logic inv, logic [127:0] exp);
      int n;
      in_valid = 1'b1; state_in = d; inv_in = inv; n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL accept_timeout: got in_ready=0 want 1");
         slot();
      end else begin
         slot();
         sb.push_back('{exp, cyc});
      end
      in_valid = 1'b0;
      state_in = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic drain(int limit);
      int n;
      n = 0;
      while (sb.size() != 0 && n < limit) begin slot(); n++; end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
   endtask

   // Main LANES=4 sequence
   initial begin
      logic [127:0] d, a_exp, b_d;
      int           n;
      rst = 1'b1; rst_sw = 1'b1; in_valid = 1'b0; inv_in = 1'b0; state_in = '0; or_mode = 1;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0; rst_sw = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_state_out", state_out, 128'h0);
      check("rst_in_ready", 128'(in_ready), 128'(1));
      slot();

      send(V_PT, 1'b0, V_SB);
      @(negedge clk); check("busy_after_accept", 128'(busy), 128'(1));
      check("in_ready_busy", 128'(in_ready), 128'(0));
      drain(50);
      send(V_SB, 1'b1, V_PT); drain(50);
      send('0, 1'b0, V_63); drain(50);

      // mode latched at acceptance while inv_in toggles
      for (int m = 0; m < 2; m++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         send(d, 1'(m), ref_sub(d, 1'(m)));
         for (int i = 0; i < BEATS + 1; i++) begin inv_in = ~inv_in; slot(); end
         drain(50);
      end

      // backpressure then back-to-back acceptance
      or_mode = 0;
      d = {$urandom, $urandom, $urandom, $urandom};
      a_exp = ref_sub(d, 1'b0);
      send(d, 1'b0, a_exp);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      slot();
      b_d = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; state_in = b_d; inv_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_in_ready", 128'(in_ready), 128'(0));
         check("bp_out_valid", 128'(out_valid), 128'(1));
         check("bp_state_out", state_out, a_exp);
      end
      slot();
      or_mode = 1;
      @(negedge clk);
      check("b2b_in_ready", 128'(in_ready), 128'(1));
      slot();
      sb.push_back('{ref_sub(b_d, 1'b1), cyc});
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b_no_bubble", 128'(busy), 128'(1));
      drain(50);

      // random traffic with random backpressure
      or_mode = 2;
      for (int t = 0; t < 40; t++) begin
         logic m;
         d = {$urandom, $urandom, $urandom, $urandom};
         m = 1'($urandom_range(0, 1));
         send(d, m, ref_sub(d, m));
         repeat ($urandom_range(0, 2)) slot();
      end
      drain(1000);

      // reset in beat 2 abandons the transaction
      or_mode = 1;
      send({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
      slot(); slot();
      rst = 1'b1;
      slot();
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check("mrst_out_valid", 128'(out_valid), 128'(0));
      check("mrst_busy", 128'(busy), 128'(0));
      check("mrst_state_out", state_out, 128'h0);
      check("mrst_in_ready", 128'(in_ready), 128'(1));
      repeat (10) slot();
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'b1, ref_sub(d, 1'b1));
      drain(50);

      n = 0;
      while (sw_done < 4 && n < 3000) begin slot(); n++; end
      if (sw_done < 4) begin
         total++; bad++;
         $display("FAIL sweep_timeout: got %0d done want 4", sw_done);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Parameter sweep: each width runs known vectors plus a few random states.
   for (genvar gi = 0; gi < 4; gi++) begin : g_sw
      localparam int SL = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
      localparam int SB = 16 / SL;
      logic         iv, ir, ov, bz, inv;
      logic [127:0] di, dout;

      aes_subbytes_iter #(.LANES(SL)) u_sw (
         .clk(clk), .rst(rst_sw), .in_valid(iv), .in_ready(ir), .state_in(di), .inv_in(inv),
         .out_valid(ov), .out_ready(1'b1), .state_out(dout), .busy(bz));

      initial begin
         logic [127:0] d, e;
         logic         m;
         int           acc, n;
         iv = 1'b0; inv = 1'b0; di = '0;
         repeat (6) @(posedge clk);
         #1;
         for (int t = 0; t < 7; t++) begin
            case (t)
               0: begin d = V_PT; m = 1'b0; e = V_SB; end
               1: begin d = V_SB; m = 1'b1; e = V_PT; end
               2: begin d = '0;   m = 1'b0; e = V_63; end
               default: begin
                  d = {$urandom, $urandom, $urandom, $urandom};
                  m = 1'($urandom_range(0, 1));
                  e = ref_sub(d, m);
               end
            endcase
            iv = 1'b1; di = d; inv = m; n = 0;
            @(negedge clk);
            while (!ir && n < 50) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            acc = cyc; iv = 1'b0; n = 0;
            @(negedge clk);
            while (!ov && n < 50) begin @(negedge clk); n++; end
            check_int($sformatf("sweep%0d_latency", SL), cyc, acc + SB);
            check($sformatf("sweep%0d_result", SL), dout, e);
            @(posedge clk); #1;
         end
         sw_done++;
      end
   end

endmodule

// File: doc/aes_subbytes_iter.md
Name: aes_subbytes_iter

Overview:
Iterative, parametrised SubBytes / InvSubBytes engine for the AES-128 datapath.
- Accepts one 128-bit state per transaction and processes LANES bytes per cycle.
- Takes 16/LANES cycles per state, trading S-box area for latency.
- Uses valid/ready handshakes on input and output.
- Sits between the round controller and ShiftRows / InvShiftRows.
- Encryption and decryption share one engine, selected per transaction by a mode bit.

Parameters:
- LANES, 4: S-box pairs (forward + inverse) instantiated. Legal values: 1, 2, 4, 8, 16. Any other value is a compile-time error.
- BEATS, 16/LANES: derived localparam, never overridden. It is the number of processing cycles per state.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: state_in and inv_in are valid.
- in_ready, output, 1: engine can accept a state this cycle.
- state_in, input, 128: input state. Byte 0 = bits [127:120], byte 15 = bits [7:0] (column-major).
- inv_in, input, 1: 0 = forward S-box (aes_sbox), 1 = inverse S-box (aes_inv_sbox).
- out_valid, output, 1: state_out holds a completed result.
- out_ready, input, 1: consumer accepts the result.
- state_out, output, 128: substituted state, same byte mapping as state_in.
- busy, output, 1: high in the BUSY state.

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - FSM goes to IDLE; beat counter = 0.
  - state_out = 128'h0; out_valid = 0; busy = 0; mode register = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset wins over any simultaneous handshake. A transaction in progress is abandoned and no out_valid is ever produced for it.
- Instances:
  - LANES aes_sbox instances and LANES aes_inv_sbox instances, both combinational, ports .a/.y.
  - Lane j of beat k operates on byte k*LANES+j.
  - Per lane, the mode register selects the forward or inverse result.
- Working register: a 128-bit work register holds the state. The beat-k bytes are overwritten in place with their substituted values; state_out is driven directly from this register.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - in_ready = 1.
    - On in_valid: load state_in into the work register, latch inv_in, counter = 0, go to BUSY.
  - BUSY:
    - in_ready = 0.
    - Each cycle: substitute the beat-[counter] bytes, then increment the counter.
    - When counter == BEATS-1: the substitution completes this cycle, go to DONE, and out_valid = 1 next cycle.
  - DONE:
    - out_valid = 1; state_out and out_valid are held stable until out_ready.
    - On out_ready with in_valid low: go to IDLE.
    - On out_ready with in_valid high: back-to-back. The new state is loaded into BUSY and in_ready = out_ready in DONE (combinational), so there is no idle bubble.
    - Without out_ready: in_ready = 0 and inputs are ignored.
- Latency: a handshake accepted at edge T gives out_valid = 1 in the cycle after edge T+BEATS. Examples: LANES=16 → 1 cycle; LANES=4 → 4 cycles; LANES=1 → 16 cycles.
- Throughput: one state per BEATS cycles with out_ready tied high.
- Mode latching: the mode is latched only at acceptance. Toggling inv_in during BUSY has no effect.
- Outputs: all outputs are registered except in_ready, which is decoded from state and out_ready.
- Counter width: $clog2(BEATS), minimum 1 bit. The counter wraps to 0 on each load and never exceeds BEATS-1.
- Handshake rules:
  - in_valid high while in_ready is low: nothing is captured. The producer must hold its data.
  - out_ready high while out_valid is low: ignored.

Test Plan:
- Forward, LANES=4: state_in = 128'h00112233445566778899aabbccddeeff, inv_in=0 → state_out = 128'h638293c31bfc33f5c4eeacea4bc12816. out_valid rises exactly 4 cycles after acceptance.
- Inverse round-trip, LANES=4: feed 128'h638293c31bfc33f5c4eeacea4bc12816 with inv_in=1 → state_out = 128'h00112233445566778899aabbccddeeff.
- Parameter sweep: LANES ∈ {1,2,8,16} on the vector above → identical result with latency 16/8/2/1. Also all-zero input → 128'h6363…63.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → state_out stable, in_ready=0, and a second in_valid is not accepted. Then out_ready=1 with in_valid=1 → second state accepted the same cycle with no bubble.
- Mode latching: toggle inv_in every cycle during BUSY → result matches the mode present at acceptance.
- Mid-operation reset: assert rst in beat 2 of LANES=4 → next cycle out_valid=0, busy=0, state_out=0, in_ready=1. The abandoned transaction never produces out_valid, and a fresh transaction then completes correctly.
